select_cursor_anim_bitmap: RTL and testbench
============================================

Name: select_cursor_anim_bitmap

Overview:
Parametrised, animated selection-cursor sprite for the game menu screens.
- Stores FRAMES bitmaps of OBJ_W x OBJ_H 8-bit RGB pixels.
- Cycles the frames on video start-of-frame ticks, optionally mirrors horizontally, and blinks on a confirm event.
- Sits between the cursor square object (which supplies offsets and InsideRectangle) and the video mux, which consumes drawingRequest/RGBout.

Parameters:
- OBJ_W, 32, sprite width in pixels.
- OBJ_H, 16, sprite height in pixels.
- FRAMES, 4, number of animation frames (>=1).
- FRAME_TICKS, 8, start-of-frame ticks per animation frame (>=1).
- FLASH_TICKS, 4, start-of-frame ticks per blink half-period (>=1).
- FLASH_COUNT, 6, visibility toggles per confirm blink (even, >=2).
- TRANSPARENT_ENCODING, 8'hFF, RGB value treated as transparent.

Ports:
- clk  in  1  pixel clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per video frame
- enable  in  1  cursor shown and animating when high
- confirm  in  1  one-cycle pulse: start blink sequence
- mirrorX  in  1  1 = horizontally mirrored sprite
- offsetX  in  11  pixel X offset from sprite top-left
- offsetY  in  11  pixel Y offset from sprite top-left
- InsideRectangle  in  1  pixel lies within the cursor bracket
- drawingRequest  out  1  pixel is to be displayed
- RGBout  out  8  pixel colour
- flash_done  out  1  one-cycle pulse when the blink sequence ends

Behaviour:
- Reset (async, resetN=0):
  - state=IDLE, frame_idx=0, tick_cnt=0, toggle_cnt=0, visible=0.
  - RGBout=8'h00, flash_done=0.
- drawingRequest = (RGBout != TRANSPARENT_ENCODING), combinational from the RGBout register.
- Pixel path (1-cycle latency): each clk, RGBout <= pixel if all of the following hold, else TRANSPARENT_ENCODING:
  - InsideRectangle=1,
  - visible=1,
  - offsetX<OBJ_W and offsetY<OBJ_H.
- Pixel addressing: rom[frame_idx][offsetY][col], where col = mirrorX ? OBJ_W-1-offsetX : offsetX.
- frame_idx, visible and the state change only on clk edges and are sampled by the pixel path the same cycle; the controller updates them on startOfFrame, so no mid-frame tearing occurs.
- FSM states:
  - IDLE:
    - visible=0; confirm is ignored.
    - enable=1 -> ANIM, with tick_cnt=0 and frame_idx unchanged.
  - ANIM:
    - visible=1.
    - On startOfFrame: tick_cnt++. When tick_cnt reaches FRAME_TICKS-1, set tick_cnt=0 and frame_idx = (frame_idx==FRAMES-1) ? 0 : frame_idx+1 (wrap).
    - confirm=1 -> FLASH, with tick_cnt=0, toggle_cnt=0, visible<=0. frame_idx is frozen for the whole of FLASH.
  - FLASH:
    - On startOfFrame: tick_cnt++. When tick_cnt reaches FLASH_TICKS-1: tick_cnt=0, visible toggles, toggle_cnt++.
    - When toggle_cnt reaches FLASH_COUNT: -> ANIM, visible=1, tick_cnt=0, and flash_done=1 for exactly one cycle.
    - confirm is ignored (no restart).
- enable=0 in any state -> IDLE on the next edge. This takes priority over every other event; tick_cnt=0, frame_idx is held, flash_done is not pulsed.
- confirm and startOfFrame in the same cycle in ANIM: FLASH entry wins and that tick is not counted.
- Counter widths: $clog2 of the respective maximum, minimum 1 bit. FRAMES=1 keeps frame_idx at 0.
- Offsets beyond the bitmap with InsideRectangle=1 produce transparent output; there is no out-of-range ROM access.

Decomposition:
- Package select_cursor_pkg holds:
  - the state enum (IDLE, ANIM, FLASH),
  - TRANSPARENT_ENCODING,
  - the default sprite dimensions.
- Sub-module select_cursor_rom: a purely combinational lookup (frame, row, col) -> 8-bit RGB holding the frame bitmaps. The top level contains the FSM, counters, mirroring and the output register.

Test Plan:
- Reset mid-ANIM at frame_idx=2 -> RGBout=8'h00, drawingRequest=1, frame_idx=0, state=IDLE until enable. The ROM is held at 8'hFF only outside the artwork.
- enable=1, FRAME_TICKS=8, FRAMES=4, 40 startOfFrame pulses -> frame_idx steps 0,1,2,3,0 every 8 ticks; it sits at 1 after tick 40.
- InsideRectangle=1, offsetX=5, offsetY=3, mirrorX toggled -> RGBout one cycle later equals rom[f][3][5], then rom[f][3][26]. offsetX=40 -> 8'hFF, drawingRequest=0.
- confirm in ANIM, FLASH_TICKS=4, FLASH_COUNT=6 -> visible pattern is 0,1,0,1,0,1 per 4-tick window. flash_done pulses once after tick 24; frame_idx is unchanged across the blink, then animation resumes.
- confirm coincident with startOfFrame, then a second confirm during FLASH -> tick not counted, no restart, flash_done still after 24 ticks.
- enable dropped during FLASH -> IDLE next cycle, drawingRequest=0, no flash_done pulse. Re-enable -> ANIM with the held frame_idx.

Source files
------------

// File: rtl/select_cursor_pkg.sv
// select_cursor_pkg: shared state encoding, transparency key and default sprite size
package select_cursor_pkg;
    typedef enum logic [1:0] {IDLE, ANIM, FLASH} state_t;
    localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;
    localparam int DEFAULT_OBJ_W = 32;
    localparam int DEFAULT_OBJ_H = 16;
endpackage

// File: rtl/select_cursor_rom.sv
// select_cursor_rom: combinational cursor artwork lookup (frame, row, col) -> RGB
module select_cursor_rom #(
    parameter int OBJ_W = 32,
    parameter int FW = 2,
    parameter logic [7:0] TRANSPARENT_ENCODING = 8'hFF
) (
    input  logic [FW-1:0] frame,
    input  logic [10:0]   row,
    input  logic [10:0]   col,
    output logic [7:0]    rgb
);
    logic [15:0] idx;
    // Each frame shifts the pattern so the animation is visible; bit 7 stays clear so art never hits the key
    assign idx = 16'(row) * 16'(OBJ_W) + 16'(col) + 16'(frame) * 16'd37;
    assign rgb = (idx[1:0] == 2'd3) ? TRANSPARENT_ENCODING : {1'b0, 7'(idx)};
endmodule

// File: rtl/select_cursor_anim_bitmap.sv
// select_cursor_anim_bitmap: animated, mirrorable, blinking menu selection cursor sprite
module select_cursor_anim_bitmap
    import select_cursor_pkg::*;
#(
    parameter int OBJ_W = DEFAULT_OBJ_W,
    parameter int OBJ_H = DEFAULT_OBJ_H,
    parameter int FRAMES = 4,
    parameter int FRAME_TICKS = 8,
    parameter int FLASH_TICKS = 4,
    parameter int FLASH_COUNT = 6,
    parameter logic [7:0] TRANSPARENT_ENCODING = select_cursor_pkg::TRANSPARENT_ENCODING
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        enable,
    input  logic        confirm,
    input  logic        mirrorX,
    input  logic [10:0] offsetX,
    input  logic [10:0] offsetY,
    input  logic        InsideRectangle,
    output logic        drawingRequest,
    output logic [7:0]  RGBout,
    output logic        flash_done
);
    localparam int FW = FRAMES > 1 ? $clog2(FRAMES) : 1;
    localparam int TMAX = FRAME_TICKS > FLASH_TICKS ? FRAME_TICKS : FLASH_TICKS;
    localparam int TW = TMAX > 1 ? $clog2(TMAX) : 1;
    localparam int CW = $clog2(FLASH_COUNT + 1);

    state_t        state, state_n;
    logic [FW-1:0] frame_idx, frame_n;
    logic [TW-1:0] tick_cnt, tick_n;
    logic [CW-1:0] toggle_cnt, toggle_n;
    logic          visible, visible_n, done_n;
    logic [10:0]   col;
    logic [7:0]    rom_rgb, rgb_n;

    select_cursor_rom #(.OBJ_W(OBJ_W), .FW(FW), .TRANSPARENT_ENCODING(TRANSPARENT_ENCODING)) u_rom (
        .frame(frame_idx),
        .row(offsetY),
        .col(col),
        .rgb(rom_rgb)
    );

    assign col = mirrorX ? 11'(OBJ_W - 1) - offsetX : offsetX;
    assign rgb_n = (InsideRectangle && visible && offsetX < 11'(OBJ_W) && offsetY < 11'(OBJ_H)) ? rom_rgb : TRANSPARENT_ENCODING;
    assign drawingRequest = RGBout != TRANSPARENT_ENCODING;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            frame_idx  <= '0;
            tick_cnt   <= '0;
            toggle_cnt <= '0;
            visible    <= 1'b0;
            flash_done <= 1'b0;
            RGBout     <= 8'h00;
        end else begin
            state      <= state_n;
            frame_idx  <= frame_n;
            tick_cnt   <= tick_n;
            toggle_cnt <= toggle_n;
            visible    <= visible_n;
            flash_done <= done_n;
            RGBout     <= rgb_n;
        end
    end

    always_comb begin
        state_n   = state;
        frame_n   = frame_idx;
        tick_n    = tick_cnt;
        toggle_n  = toggle_cnt;
        visible_n = visible;
        done_n    = 1'b0;
        if (!enable) begin
            state_n   = IDLE;
            tick_n    = '0;
            visible_n = 1'b0;
        end else if (state == IDLE) begin
            state_n   = ANIM;
            tick_n    = '0;
            visible_n = 1'b1;
        end else if (state == ANIM) begin
            visible_n = 1'b1;
            // A confirm swallows a coincident start-of-frame tick
            if (confirm) begin
                state_n   = FLASH;
                tick_n    = '0;
                toggle_n  = '0;
                visible_n = 1'b0;
            end else if (startOfFrame) begin
                tick_n = (tick_cnt == TW'(FRAME_TICKS - 1)) ? '0 : tick_cnt + 1'b1;
                if (tick_cnt == TW'(FRAME_TICKS - 1))
                    frame_n = (frame_idx == FW'(FRAMES - 1)) ? '0 : frame_idx + 1'b1;
            end
        end else if (state == FLASH && startOfFrame) begin
            tick_n = (tick_cnt == TW'(FLASH_TICKS - 1)) ? '0 : tick_cnt + 1'b1;
            if (tick_cnt == TW'(FLASH_TICKS - 1)) begin
                toggle_n  = toggle_cnt + 1'b1;
                visible_n = !visible;
                // The last toggle lands directly back in ANIM with the cursor shown
                if (toggle_cnt == CW'(FLASH_COUNT - 1)) begin
                    state_n   = ANIM;
                    visible_n = 1'b1;
                    done_n    = 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_select_cursor_anim_bitmap.sv
// tb_select_cursor_anim_bitmap: directed + randomized checks against a tick-counting behavioural model
module tb_select_cursor_anim_bitmap;
    localparam int OBJ_W = 32;
    localparam int OBJ_H = 16;
    localparam int FRAMES = 4;
    localparam int FRAME_TICKS = 8;
    localparam int FLASH_TICKS = 4;
    localparam int FLASH_COUNT = 6;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0, enable = 1'b0, confirm = 1'b0, mirrorX = 1'b0;
    logic [10:0] offsetX = '0, offsetY = '0;
    logic        InsideRectangle = 1'b0;
    logic        drawingRequest, flash_done;
    logic [7:0]  RGBout;

    int compared = 0, mismatched = 0, done_seen = 0;
    // Model: mode 0 hidden, 1 animating, 2 blinking; n = ticks counted since entering the mode
    int m_mode = 0, m_base = 0, m_n = 0;

    always #5 clk = ~clk;

    select_cursor_anim_bitmap #(
        .OBJ_W(OBJ_W), .OBJ_H(OBJ_H), .FRAMES(FRAMES), .FRAME_TICKS(FRAME_TICKS),
        .FLASH_TICKS(FLASH_TICKS), .FLASH_COUNT(FLASH_COUNT), .TRANSPARENT_ENCODING(8'hFF)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
        .confirm(confirm), .mirrorX(mirrorX), .offsetX(offsetX), .offsetY(offsetY),
        .InsideRectangle(InsideRectangle), .drawingRequest(drawingRequest),
        .RGBout(RGBout), .flash_done(flash_done)
    );

    function automatic logic [7:0] art(input int f, input int r, input int c);
        int idx = r * OBJ_W + c + f * 37;
        return (idx % 4 == 3) ? 8'hFF : 8'(idx % 128);
    endfunction

    function automatic int cur_frame();
        return (m_mode == 1) ? (m_base + m_n / FRAME_TICKS) % FRAMES : m_base;
    endfunction

    function automatic bit cur_vis();
        return (m_mode == 1) ? 1'b1 : (m_mode == 2) ? 1'((m_n / FLASH_TICKS) % 2) : 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit sof, input bit conf, input bit en);
        logic [7:0] exp_rgb;
        bit exp_done = 1'b0;
        int f = cur_frame();
        int c = mirrorX ? OBJ_W - 1 - int'(offsetX) : int'(offsetX);
        startOfFrame = sof;
        confirm = conf;
        enable = en;
        exp_rgb = (InsideRectangle && cur_vis() && offsetX < OBJ_W && offsetY < OBJ_H) ? art(f, int'(offsetY), c) : 8'hFF;
        if (!en) begin
            m_base = f; m_mode = 0; m_n = 0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_n = 0;
        end else if (m_mode == 1) begin
            if (conf) begin m_base = f; m_mode = 2; m_n = 0; end
            else if (sof) m_n++;
        end else if (sof) begin
            m_n++;
            if (m_n == FLASH_TICKS * FLASH_COUNT) begin m_mode = 1; m_n = 0; exp_done = 1'b1; end
        end
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        confirm = 1'b0;
        if (flash_done) done_seen++;
        chk("rgb", RGBout, exp_rgb);
        chk("draw_req", 8'(drawingRequest), 8'(exp_rgb != 8'hFF));
        chk("flash_done", 8'(flash_done), 8'(exp_done));
    endtask

    task automatic rnd_pix();
        InsideRectangle = $urandom_range(0, 7) != 0;
        offsetX = 11'($urandom_range(0, 39));
        offsetY = 11'($urandom_range(0, 19));
        mirrorX = 1'($urandom_range(0, 1));
    endtask

    task automatic rcyc(input bit sof, input bit conf, input bit en);
        rnd_pix();
        cyc(sof, conf, en);
    endtask

    task automatic ticks(input int n, input bit en);
        repeat (n) begin
            rcyc(1'b1, 1'b0, en);
            rcyc(1'b0, 1'b0, en);
        end
    endtask

    task automatic set_pix(input int x, input int y, input bit m);
        InsideRectangle = 1'b1;
        offsetX = 11'(x);
        offsetY = 11'(y);
        mirrorX = m;
    endtask

    initial begin
        #1;
        chk("reset_rgb", RGBout, 8'h00);
        chk("reset_draw", 8'(drawingRequest), 8'h01);
        chk("reset_done", 8'(flash_done), 8'h00);
        @(posedge clk); #1;
        resetN = 1'b1;
        rcyc(1'b0, 1'b0, 1'b0);
        rcyc(1'b0, 1'b0, 1'b0);

        // Animate to frame 2, then reset asynchronously mid-cycle
        rcyc(1'b0, 1'b0, 1'b1);
        ticks(16, 1'b1);
        #2 resetN = 1'b0;
        #1;
        chk("midreset_rgb", RGBout, 8'h00);
        chk("midreset_draw", 8'(drawingRequest), 8'h01);
        @(posedge clk); #1;
        resetN = 1'b1;
        m_mode = 0; m_base = 0; m_n = 0;
        repeat (3) rcyc(1'b0, 1'b0, 1'b0);
        set_pix(0, 0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("idle_hidden", 8'(drawingRequest), 8'h00);

        // 40 ticks of animation from frame 0 lands on frame 1
        rcyc(1'b0, 1'b0, 1'b1);
        ticks(40, 1'b1);
        set_pix(0, 0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("frame_after_40", RGBout, 8'h25);

        // Mirroring and out-of-range offsets
        set_pix(5, 3, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        set_pix(5, 3, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        set_pix(40, 3, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("oob_x_draw", 8'(drawingRequest), 8'h00);
        set_pix(3, 16, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("oob_y_rgb", RGBout, 8'hFF);

        // Full blink sequence
        done_seen = 0;
        rcyc(1'b0, 1'b1, 1'b1);
        ticks(FLASH_TICKS * FLASH_COUNT, 1'b1);
        ticks(3, 1'b1);
        chk("blink_done_count", 8'(done_seen), 8'd1);

        // Confirm coincident with a tick, plus an ignored second confirm
        done_seen = 0;
        rcyc(1'b1, 1'b1, 1'b1);
        ticks(5, 1'b1);
        rcyc(1'b0, 1'b1, 1'b1);
        ticks(FLASH_TICKS * FLASH_COUNT - 5, 1'b1);
        rcyc(1'b0, 1'b0, 1'b1);
        chk("coincident_done_count", 8'(done_seen), 8'd1);

        // Enable dropped mid-blink
        done_seen = 0;
        rcyc(1'b0, 1'b1, 1'b1);
        ticks(6, 1'b1);
        set_pix(1, 1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("drop_hidden", 8'(drawingRequest), 8'h00);
        ticks(30, 1'b0);
        chk("drop_no_done", 8'(done_seen), 8'd0);
        rcyc(1'b0, 1'b0, 1'b1);
        ticks(10, 1'b1);

        // Randomized mix
        repeat (800) rcyc($urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 49) != 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
